lcd_spi_rx: RTL
===============

// Module: lcd_spi_rx
// PURPOSE
//  Receive end of the 4-wire LCD SPI link (cs, dc, sclk, mosi), i.e. the panel side of the LCD write path.
//  Oversamples the bus on the system clock, deserialises 9-bit words {dc, byte} and decodes CASET/RASET/RAMWR.
//  Outputs the write window and a stream of RGB565 pixels with x/y coordinates.
//  Used as a loopback checker and panel model behind the LCD SPI master; also usable on-board for UART readback.
// PARAMETERS
//  SYNC_STAGES  2       flops in each input synchroniser (>=2)
//  H_RES        240     default x_end+1 after reset
//  V_RES        320     default y_end+1 after reset
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst          in   1   asynchronous, active-high reset
//  spi_cs       in   1   chip select, active low, asynchronous to clk
//  spi_dc       in   1   0=command, 1=data; sampled with bit 0 of each byte
//  spi_sclk     in   1   SPI mode 0 clock; mosi sampled on rising edge
//  spi_mosi     in   1   serial data, MSB first
//  rx_data      out  9   {dc, byte} of last complete word
//  rx_valid     out  1   1-cycle strobe: rx_data updated
//  frame_err    out  1   1-cycle strobe: cs rose with 1..7 bits of a byte pending
//  x_start/x_end out 9   current column window (from CASET)
//  y_start/y_end out 9   current row window (from RASET)
//  pix_data     out  16  RGB565 pixel, high byte first on the wire
//  pix_x/pix_y  out  9   coordinate of pix_data
//  pix_valid    out  1   1-cycle strobe per pixel
//  frame_done   out  1   1-cycle strobe together with the pixel at (x_end, y_end)
// BEHAVIOUR
//  Reset: all strobes 0, rx_data 0, x_start=y_start=0, x_end=H_RES-1, y_end=V_RES-1, pix_* 0, state IDLE.
//  Each SPI input passes through SYNC_STAGES flops. sclk rising edge = last synchronised stage 1, previous 0.
//  Timing requirement: sclk high and low each >= SYNC_STAGES+1 clk periods. Faster sclk is unsupported.
//  Bit counter counts 0..7 while cs=0 and is cleared whenever cs=1. The 8th edge loads rx_data and strobes rx_valid on the next clk.
//  That makes rx_valid SYNC_STAGES+2 clk after the 8th raw sclk rise. The counter then wraps to 0 with no gap required.
//  cs rising with bit count 1..7: byte discarded, frame_err strobes, no rx_valid.
//  Decoder FSM, advanced only on rx_valid:
//   IDLE: dc=0 byte 2A -> CASET, 2B -> RASET, 2C -> RAMWR. Any other command -> IDLE. Data bytes are ignored.
//   CASET/RASET: collect 4 data bytes SH,SL,EH,EL. start={SH[0],SL}, end={EH[0],EL}.
//    Window registers update only on the 4th byte, then return to IDLE.
//    If start>end the update still happens; pixels then clamp: the row wraps when x==x_end.
//   RAMWR: on entry pix_x=x_start, pix_y=y_start, and the half-byte flag clears.
//    Data bytes pair as hi,lo. On each lo byte pix_valid strobes with the current coordinate.
//    Coordinate advance, then:
//     x==x_end -> x=x_start and y+1.
//     additionally y==y_end -> y=y_start and frame_done strobes with that pixel.
//  Any dc=0 byte in CASET/RASET/RAMWR aborts that state: partial params are dropped and a pending hi byte is lost.
//   The byte is then decoded as a new command in the same cycle.
//  cs rising does not change FSM state; RAMWR continues across cs pulses, matching panel behaviour.
//  pix_valid is coincident with the rx_valid of the lo byte; registered outputs, no combinational in->out path.
//  Assertion of rst at any time returns everything to reset values immediately.
// CONFIGURATION
//  LCD_SPI_RX_READ_EN defined: adds outputs rd_req (1-cycle strobe) and rd_cmd[7:0].
//   Strobes on commands 04/09/0A (RDDID/RDDST/RDDPM) so a bench can inject responses.
//  Undefined: the ports are absent and those commands fall into the "other command" path.
// STRUCTURE
//  Package lcd_spi_pkg: localparams CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C, read command codes, FSM state encodings.
//  Sub-module lcd_spi_deser: synchronisers, edge detect, bit counter, rx_data/rx_valid/frame_err.
//  lcd_spi_rx holds the decoder FSM, window registers and pixel counter.
// TESTING
//  1 Send cmd 2A, data 00 0A 00 13 -> one rx_valid per byte, rx_data 9'h02A then 9'h100..; x_start=10, x_end=19 after the 4th byte only.
//  2 Window x 0..1, y 0..1, RAMWR + 8 data bytes F8 00 07 E0 00 1F FF FF.
//    -> pix (0,0)=F800, (1,0)=07E0, (0,1)=001F, (1,1)=FFFF; frame_done with the 4th pixel only.
//  3 RAMWR, 3 data bytes, then cmd 2C, 2 bytes 12 34 -> exactly 2 pixels; the 2nd = 1234 at (x_start, y_start).
//  4 cs low, 5 sclk pulses, cs high -> frame_err=1 for one cycle, no rx_valid. The next full byte is received correctly.
//  5 Assert rst mid-CASET after 2 params, release, send 2B 00 00 00 09 -> y_end=9; x window still reset default 0..H_RES-1.
//  6 sclk half period = SYNC_STAGES+1 clk, 256 random words -> all match; with LCD_SPI_RX_READ_EN, cmd 04 gives rd_req with rd_cmd=04.

Source files
------------

// File: rtl/lcd_spi_pkg.sv
// Shared command codes and decoder state encoding for the LCD SPI receive path.
package lcd_spi_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam logic [7:0] CMD_RDDID = 8'h04;
  localparam logic [7:0] CMD_RDDST = 8'h09;
  localparam logic [7:0] CMD_RDDPM = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CASET = 2'd1,
    ST_RASET = 2'd2,
    ST_RAMWR = 2'd3
  } rx_state_t;

  function automatic logic is_read_cmd(input logic [7:0] cmd);
    return (cmd == CMD_RDDID) || (cmd == CMD_RDDST) || (cmd == CMD_RDDPM);
  endfunction

  function automatic rx_state_t cmd_state(input logic [7:0] cmd);
    case (cmd)
      CMD_CASET: return ST_CASET;
      CMD_RASET: return ST_RASET;
      CMD_RAMWR: return ST_RAMWR;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lcd_spi_deser.sv
// Oversampling SPI mode-0 deserialiser: synchronisers, sclk edge detect, 9-bit {dc, byte} words.
module lcd_spi_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       word_vld,
  output logic [8:0] word,
  output logic [8:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] cs_sync, dc_sync, sclk_sync, mosi_sync;
  logic       sclk_d, cs_d;
  logic       vld_p0, cs_p0, cs_rise_p0, dc_p0, mosi_p0;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;

  // Stage p0: synchronise, detect sclk rise and cs rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync    <= '1;
      dc_sync    <= '0;
      sclk_sync  <= '0;
      mosi_sync  <= '0;
      sclk_d     <= 1'b0;
      cs_d       <= 1'b1;
      vld_p0     <= 1'b0;
      cs_p0      <= 1'b1;
      cs_rise_p0 <= 1'b0;
      dc_p0      <= 1'b0;
      mosi_p0    <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      dc_sync    <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d     <= sclk_sync[SYNC_STAGES-1];
      cs_d       <= cs_sync[SYNC_STAGES-1];
      vld_p0     <= sclk_sync[SYNC_STAGES-1] & ~sclk_d & ~cs_sync[SYNC_STAGES-1];
      cs_p0      <= cs_sync[SYNC_STAGES-1];
      cs_rise_p0 <= cs_sync[SYNC_STAGES-1] & ~cs_d;
      dc_p0      <= dc_sync[SYNC_STAGES-1];
      mosi_p0    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  // The decoder consumes the completed word in the same edge that registers rx_data
  assign word_vld = vld_p0 && (bit_cnt == 3'd7);
  assign word     = {dc_p0, shreg, mosi_p0};

  // Stage p1: bit counter, shift register, word/strobe outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      rx_data   <= 9'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= word_vld;
      frame_err <= cs_rise_p0 && (bit_cnt != 3'd0);
      if (cs_p0) begin
        bit_cnt <= 3'd0;
      end else if (vld_p0) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {shreg[5:0], mosi_p0};
      end
      if (word_vld) rx_data <= word;
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// LCD SPI panel-side receiver: CASET/RASET/RAMWR decoder, write window and RGB565 pixel stream.
// Define LCD_SPI_RX_READ_EN to add rd_req/rd_cmd strobes for read commands 04/09/0A.
module lcd_spi_rx
  import lcd_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int H_RES       = 240,
  parameter int V_RES       = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_cs,
  input  logic        spi_dc,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic [8:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [8:0]  x_start,
  output logic [8:0]  x_end,
  output logic [8:0]  y_start,
  output logic [8:0]  y_end,
  output logic [15:0] pix_data,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_valid,
`ifdef LCD_SPI_RX_READ_EN
  output logic        rd_req,
  output logic [7:0]  rd_cmd,
`endif
  output logic        frame_done
);

  localparam logic [8:0] X_END_RST = 9'(H_RES - 1);
  localparam logic [8:0] Y_END_RST = 9'(V_RES - 1);

  logic       word_vld;
  logic [8:0] word;
  rx_state_t  state, state_nxt;
  logic [1:0] param_cnt;
  logic       start_hi, end_hi, half;
  logic [7:0] start_lo, hi_byte;
  logic [8:0] cur_x, cur_y;

  lcd_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk      (clk),
    .rst      (rst),
    .spi_cs   (spi_cs),
    .spi_dc   (spi_dc),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .word_vld (word_vld),
    .word     (word),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Any command byte re-decodes from scratch, whatever state is active
  always_comb begin
    state_nxt = state;
    if (word_vld) begin
      if (!word[8]) begin
        state_nxt = cmd_state(word[7:0]);
      end else if ((state == ST_CASET || state == ST_RASET) && param_cnt == 2'd3) begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      param_cnt  <= 2'd0;
      start_hi   <= 1'b0;
      start_lo   <= 8'd0;
      end_hi     <= 1'b0;
      half       <= 1'b0;
      hi_byte    <= 8'd0;
      cur_x      <= 9'd0;
      cur_y      <= 9'd0;
      x_start    <= 9'd0;
      x_end      <= X_END_RST;
      y_start    <= 9'd0;
      y_end      <= Y_END_RST;
      pix_data   <= 16'd0;
      pix_x      <= 9'd0;
      pix_y      <= 9'd0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef LCD_SPI_RX_READ_EN
      rd_req     <= 1'b0;
      rd_cmd     <= 8'd0;
`endif
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef LCD_SPI_RX_READ_EN
      rd_req     <= 1'b0;
`endif
      if (word_vld) begin
        if (!word[8]) begin
          param_cnt <= 2'd0;
          half      <= 1'b0;
          if (word[7:0] == CMD_RAMWR) begin
            cur_x <= x_start;
            cur_y <= y_start;
            pix_x <= x_start;
            pix_y <= y_start;
          end
`ifdef LCD_SPI_RX_READ_EN
          if (is_read_cmd(word[7:0])) begin
            rd_req <= 1'b1;
            rd_cmd <= word[7:0];
          end
`endif
        end else begin
          case (state)
            ST_CASET, ST_RASET: begin
              param_cnt <= param_cnt + 2'd1;
              case (param_cnt)
                2'd0: start_hi <= word[0];
                2'd1: start_lo <= word[7:0];
                2'd2: end_hi   <= word[0];
                default: begin
                  if (state == ST_CASET) begin
                    x_start <= {start_hi, start_lo};
                    x_end   <= {end_hi, word[7:0]};
                  end else begin
                    y_start <= {start_hi, start_lo};
                    y_end   <= {end_hi, word[7:0]};
                  end
                end
              endcase
            end
            ST_RAMWR: begin
              if (!half) begin
                hi_byte <= word[7:0];
                half    <= 1'b1;
              end else begin
                half      <= 1'b0;
                pix_valid <= 1'b1;
                pix_data  <= {hi_byte, word[7:0]};
                pix_x     <= cur_x;
                pix_y     <= cur_y;
                // Equality test only, so a start>end window wraps through 511 before clamping
                if (cur_x == x_end) begin
                  cur_x <= x_start;
                  if (cur_y == y_end) begin
                    cur_y      <= y_start;
                    frame_done <= 1'b1;
                  end else begin
                    cur_y <= cur_y + 9'd1;
                  end
                end else begin
                  cur_x <= cur_x + 9'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
